riscv_regfile: RTL and testbench
================================

RISCV_REGFILE -- requirements
Module: riscv_regfile

Interface
REQ-001 The module SHALL have parameter N_REG, default 32, giving the number of architectural registers (addresses 0..N_REG-1).
REQ-002 The module SHALL use data width `XLEN (global define, 32 for RV32I) for every data port.
REQ-003 The module SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port i_rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port i_rs1_addr, input, $clog2(N_REG) bits: read port 1 address.
REQ-006 The module SHALL have port i_rs2_addr, input, $clog2(N_REG) bits: read port 2 address.
REQ-007 The module SHALL have port o_rs1_data, output, `XLEN bits: read port 1 data.
REQ-008 The module SHALL have port o_rs2_data, output, `XLEN bits: read port 2 data.
REQ-009 The module SHALL have port i_rd_we, input, 1 bit: write-back enable.
REQ-010 The module SHALL have port i_rd_addr, input, $clog2(N_REG) bits: write-back destination.
REQ-011 The module SHALL have port i_rd_data, input, `XLEN bits: write-back data.
REQ-012 The module SHALL have port i_rsv_en, input, 1 bit: reserve a destination (instruction issued, result pending).
REQ-013 The module SHALL have port i_rsv_addr, input, $clog2(N_REG) bits: register to reserve.
REQ-014 The module SHALL have port o_rs1_busy, output, 1 bit: rs1 has a pending write.
REQ-015 The module SHALL have port o_rs2_busy, output, 1 bit: rs2 has a pending write.

Function
REQ-016 The write port SHALL decode i_rd_addr to one-hot enables, and SHALL update only the addressed register on the rising edge when i_rd_we=1.
REQ-017 Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never report busy or accept a reservation.
REQ-018 Read ports SHALL be combinational (0-cycle latency) from the address and stored state; both ports MAY address the same register.
REQ-019 Each register SHALL hold a busy bit: set on the edge where i_rsv_en=1 and i_rsv_addr matches; cleared on the edge where i_rd_we=1 and i_rd_addr matches.
REQ-020 When a reserve and a write hit the same nonzero register in the same cycle, set SHALL win: data is written and the busy bit ends at 1 (a back-to-back producer).
REQ-021 A reserve of an already-busy register SHALL keep it busy; a write to a non-busy register SHALL update data and leave busy at 0.
REQ-022 o_rsN_busy SHALL be the busy bit of the addressed register (subject to REQ-027/028).
REQ-023 Out-of-range addresses (>= N_REG, non-power-of-2 N_REG) SHALL read 0 and not busy, and writes or reserves to them SHALL be ignored.

Reset
REQ-024 i_rstn=0 SHALL asynchronously clear all data registers to 0 and all busy bits to 0, with no clock required.
REQ-025 During reset, every output SHALL be 0: o_rs1_data=o_rs2_data=0 and o_rs1_busy=o_rs2_busy=0.
REQ-026 A reset asserted in the same cycle as a write or reserve SHALL discard that write or reserve; the first update is taken at the first rising edge with i_rstn=1.

Configuration
REQ-027 With RISCV_RF_BYPASS_EN defined, a read in the same cycle as i_rd_we=1 to the same nonzero address SHALL return i_rd_data, and busy SHALL read 0 unless a same-address reserve is also active in that cycle.
REQ-028 Without RISCV_RF_BYPASS_EN, reads SHALL return stored values only: the new data and the cleared busy bit become visible the cycle after the write edge.

Verification
REQ-029 Reset then read all addresses -> every data output 0 and every busy output 0.
REQ-030 Write x5=0xDEADBEEF; next cycle read rs1=5, rs2=5 -> both 0xDEADBEEF; write x0=0x12345678 -> read x0 returns 0.
REQ-031 Reserve x7, then read rs1=7 -> busy=1 until the write-back edge; write x7=0xA5A5A5A5 -> busy=0 and data 0xA5A5A5A5 on the following cycle.
REQ-032 Same-cycle reserve and write of x9=0x1 -> after the edge, x9 data=0x1 and busy=1.
REQ-033 Same-cycle write x3=0xCAFEF00D while reading rs1=3 -> 0xCAFEF00D with RISCV_RF_BYPASS_EN defined; old value 0 without it.
REQ-034 Assert i_rstn low asynchronously between edges after loading x1..x31 -> outputs go to 0 immediately, and all registers read 0 after release.

Source files
------------

// File: rtl/riscv_regfile.sv
// RISC-V integer register file: two combinational read ports, one write port, and a
// per-register busy (scoreboard) bit. Define RISCV_RF_BYPASS_EN to forward same-cycle write-back to reads.

`ifndef XLEN
`define XLEN 32
`endif

module riscv_regfile_entry #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_we,
    input  logic [W-1:0] i_wdata,
    input  logic         i_rsv,
    output logic [W-1:0] o_data,
    output logic         o_busy
);

    logic [W-1:0] data_d, data_q;
    logic         busy_d, busy_q;

    // A reserve on the same edge as the write-back wins: the next producer is already in flight.
    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        if (i_we) begin
            data_d = i_wdata;
            busy_d = 1'b0;
        end
        if (i_rsv) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign o_data = data_q;
    assign o_busy = busy_q;

endmodule

module riscv_regfile #(
    parameter int N_REG = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic [$clog2(N_REG)-1:0] i_rs1_addr,
    input  logic [$clog2(N_REG)-1:0] i_rs2_addr,
    output logic [`XLEN-1:0]         o_rs1_data,
    output logic [`XLEN-1:0]         o_rs2_data,
    input  logic                     i_rd_we,
    input  logic [$clog2(N_REG)-1:0] i_rd_addr,
    input  logic [`XLEN-1:0]         i_rd_data,
    input  logic                     i_rsv_en,
    input  logic [$clog2(N_REG)-1:0] i_rsv_addr,
    output logic                     o_rs1_busy,
    output logic                     o_rs2_busy
);

    localparam int AW = $clog2(N_REG);
    localparam int XW = `XLEN;

    // x0 has no storage; decoders only cover 1..N_REG-1, so x0 and out-of-range
    // addresses naturally select nothing and read as zero / not busy.
    logic [N_REG-1:1]         wr_hit, rsv_hit, rs1_sel, rs2_sel;
    logic [N_REG-1:1][XW-1:0] rf_data;
    logic [N_REG-1:1]         rf_busy;
    logic [XW-1:0]            rs1_data, rs2_data;
    logic                     rs1_busy, rs2_busy;

    always_comb begin
        wr_hit  = '0;
        rsv_hit = '0;
        rs1_sel = '0;
        rs2_sel = '0;
        for (int i = 1; i < N_REG; i++) begin
            wr_hit[i]  = i_rd_we  && (i_rd_addr  == AW'(i));
            rsv_hit[i] = i_rsv_en && (i_rsv_addr == AW'(i));
            rs1_sel[i] = (i_rs1_addr == AW'(i));
            rs2_sel[i] = (i_rs2_addr == AW'(i));
        end
    end

    generate
        for (genvar g = 1; g < N_REG; g++) begin : g_reg
            riscv_regfile_entry #(.W(XW)) u_entry (
                .i_clk   (i_clk),
                .i_rstn  (i_rstn),
                .i_we    (wr_hit[g]),
                .i_wdata (i_rd_data),
                .i_rsv   (rsv_hit[g]),
                .o_data  (rf_data[g]),
                .o_busy  (rf_busy[g])
            );
        end
    endgenerate

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        for (int i = 1; i < N_REG; i++) begin
            rs1_data = rs1_data | (rs1_sel[i] ? rf_data[i] : '0);
            rs2_data = rs2_data | (rs2_sel[i] ? rf_data[i] : '0);
        end
        rs1_busy = |(rs1_sel & rf_busy);
        rs2_busy = |(rs2_sel & rf_busy);
`ifdef RISCV_RF_BYPASS_EN
        // Forward the write-back; busy shows its post-edge value (set only if re-reserved).
        if (|(rs1_sel & wr_hit)) begin
            rs1_data = i_rd_data;
            rs1_busy = |(rs1_sel & rsv_hit);
        end
        if (|(rs2_sel & wr_hit)) begin
            rs2_data = i_rd_data;
            rs2_busy = |(rs2_sel & rsv_hit);
        end
`endif
    end

    // Gate with reset so forwarded write data cannot leak out while in reset.
    assign o_rs1_data = i_rstn ? rs1_data : '0;
    assign o_rs2_data = i_rstn ? rs2_data : '0;
    assign o_rs1_busy = i_rstn & rs1_busy;
    assign o_rs2_busy = i_rstn & rs2_busy;

endmodule

// File: tb/tb_riscv_regfile.sv
// Self-checking bench for riscv_regfile: directed scenarios plus randomized traffic
// compared against an array-based reference model.

`ifndef XLEN
`define XLEN 32
`endif

module tb_riscv_regfile;

    localparam int N_REG = 32;
    localparam int AW    = $clog2(N_REG);
    localparam int XW    = `XLEN;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic [AW-1:0] i_rs1_addr = '0, i_rs2_addr = '0, i_rd_addr = '0, i_rsv_addr = '0;
    logic [XW-1:0] i_rd_data = '0;
    logic          i_rd_we = 1'b0, i_rsv_en = 1'b0;
    logic [XW-1:0] o_rs1_data, o_rs2_data;
    logic          o_rs1_busy, o_rs2_busy;

    int checks = 0;
    int errors = 0;

    logic [XW-1:0] mdata [N_REG];
    bit            mbusy [N_REG];

    riscv_regfile #(.N_REG(N_REG)) dut (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_rs1_addr (i_rs1_addr),
        .i_rs2_addr (i_rs2_addr),
        .o_rs1_data (o_rs1_data),
        .o_rs2_data (o_rs2_data),
        .i_rd_we    (i_rd_we),
        .i_rd_addr  (i_rd_addr),
        .i_rd_data  (i_rd_data),
        .i_rsv_en   (i_rsv_en),
        .i_rsv_addr (i_rsv_addr),
        .o_rs1_busy (o_rs1_busy),
        .o_rs2_busy (o_rs2_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [XW-1:0] exp_data(input int a);
        if (!i_rstn || a == 0 || a >= N_REG) return '0;
`ifdef RISCV_RF_BYPASS_EN
        if (i_rd_we && int'(i_rd_addr) == a) return i_rd_data;
`endif
        return mdata[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (!i_rstn || a == 0 || a >= N_REG) return 1'b0;
`ifdef RISCV_RF_BYPASS_EN
        if (i_rd_we && int'(i_rd_addr) == a) return i_rsv_en && int'(i_rsv_addr) == a;
`endif
        return mbusy[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N_REG; i++) begin
            mdata[i] = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    // Apply the architectural update rules to the model, then let the edge happen.
    task automatic tick();
        if (i_rstn) begin
            if (i_rd_we && i_rd_addr != 0) begin
                mdata[i_rd_addr] = i_rd_data;
                mbusy[i_rd_addr] = 1'b0;
            end
            if (i_rsv_en && i_rsv_addr != 0) mbusy[i_rsv_addr] = 1'b1;
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_rd_we  = 1'b0;
        i_rsv_en = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        model_clear();
        @(posedge i_clk);
        @(posedge i_clk);
        #2;
        i_rs1_addr = 5'd5;
        i_rs2_addr = 5'd31;
        #1;
        checks++;
        if (o_rs1_data !== '0 || o_rs2_data !== '0 || o_rs1_busy !== 1'b0 || o_rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got %h %h %b %b, need all zero", o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy);
        end
        i_rstn = 1'b1;
        for (int a = 0; a < N_REG; a++) begin
            i_rs1_addr = AW'(a);
            i_rs2_addr = AW'(N_REG - 1 - a);
            #1;
            checks++;
            if (o_rs1_data !== '0 || o_rs2_data !== '0 || o_rs1_busy !== 1'b0 || o_rs2_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_read a=%0d: got %h %h %b %b, need all zero", a, o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy);
            end
        end
    endtask

    task automatic test_write_read();
        @(posedge i_clk);
        #1;
        i_rd_we = 1'b1; i_rd_addr = 5'd5; i_rd_data = 32'hDEADBEEF;
        tick();
        idle();
        i_rs1_addr = 5'd5; i_rs2_addr = 5'd5;
        #1;
        checks++;
        if (o_rs1_data !== 32'hDEADBEEF || o_rs2_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL write_x5: got %h %h, need deadbeef", o_rs1_data, o_rs2_data);
        end
        i_rd_we = 1'b1; i_rd_addr = 5'd0; i_rd_data = 32'h12345678;
        i_rs1_addr = 5'd0;
        #1;
        checks++;
        if (o_rs1_data !== '0) begin
            errors++;
            $display("FAIL x0_same_cycle: got %h, need 0", o_rs1_data);
        end
        tick();
        idle();
        checks++;
        if (o_rs1_data !== '0 || o_rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL x0_write: got %h busy %b, need 0/0", o_rs1_data, o_rs1_busy);
        end
        i_rsv_en = 1'b1; i_rsv_addr = 5'd0;
        tick();
        idle();
        checks++;
        if (o_rs1_busy !== 1'b0) begin
            errors++;
            $display("FAIL x0_reserve: got busy %b, need 0", o_rs1_busy);
        end
    endtask

    task automatic test_reserve();
        i_rsv_en = 1'b1; i_rsv_addr = 5'd7;
        tick();
        idle();
        i_rs1_addr = 5'd7;
        #1;
        checks++;
        if (o_rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL reserve_x7: got busy %b, need 1", o_rs1_busy);
        end
        tick();
        checks++;
        if (o_rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL reserve_hold: got busy %b, need 1", o_rs1_busy);
        end
        i_rd_we = 1'b1; i_rd_addr = 5'd7; i_rd_data = 32'hA5A5A5A5;
        #1;
        checks++;
`ifdef RISCV_RF_BYPASS_EN
        if (o_rs1_busy !== 1'b0 || o_rs1_data !== 32'hA5A5A5A5) begin
`else
        if (o_rs1_busy !== 1'b1 || o_rs1_data !== '0) begin
`endif
            errors++;
            $display("FAIL wb_cycle_x7: got %h busy %b", o_rs1_data, o_rs1_busy);
        end
        tick();
        idle();
        checks++;
        if (o_rs1_busy !== 1'b0 || o_rs1_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL writeback_x7: got %h busy %b, need a5a5a5a5/0", o_rs1_data, o_rs1_busy);
        end
    endtask

    task automatic test_same_cycle();
        i_rd_we = 1'b1; i_rd_addr = 5'd9; i_rd_data = 32'h1;
        i_rsv_en = 1'b1; i_rsv_addr = 5'd9;
        i_rs2_addr = 5'd9;
        #1;
        checks++;
`ifdef RISCV_RF_BYPASS_EN
        if (o_rs2_busy !== 1'b1 || o_rs2_data !== 32'h1) begin
`else
        if (o_rs2_busy !== 1'b0 || o_rs2_data !== '0) begin
`endif
            errors++;
            $display("FAIL same_cycle_view: got %h busy %b", o_rs2_data, o_rs2_busy);
        end
        tick();
        idle();
        checks++;
        if (o_rs2_data !== 32'h1 || o_rs2_busy !== 1'b1) begin
            errors++;
            $display("FAIL rsv_wins_x9: got %h busy %b, need 1/1", o_rs2_data, o_rs2_busy);
        end
    endtask

    task automatic test_bypass();
        i_rs1_addr = 5'd3;
        i_rd_we = 1'b1; i_rd_addr = 5'd3; i_rd_data = 32'hCAFEF00D;
        #1;
        checks++;
`ifdef RISCV_RF_BYPASS_EN
        if (o_rs1_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL bypass_x3: got %h, need cafef00d", o_rs1_data);
        end
`else
        if (o_rs1_data !== '0) begin
            errors++;
            $display("FAIL bypass_x3: got %h, need 0", o_rs1_data);
        end
`endif
        tick();
        idle();
        checks++;
        if (o_rs1_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL after_write_x3: got %h, need cafef00d", o_rs1_data);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, N_REG - 1));
    endfunction

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            i_rd_we    = ($urandom_range(0, 2) != 0);
            i_rd_addr  = rnd_addr();
            i_rd_data  = $urandom;
            i_rsv_en   = ($urandom_range(0, 1) != 0);
            i_rsv_addr = rnd_addr();
            i_rs1_addr = rnd_addr();
            i_rs2_addr = rnd_addr();
            #1;
            checks++;
            if (o_rs1_data !== exp_data(int'(i_rs1_addr)) || o_rs1_busy !== exp_busy(int'(i_rs1_addr))) begin
                errors++;
                $display("FAIL rand_rs1 n=%0d a=%0d: got %h/%b, need %h/%b", n, i_rs1_addr, o_rs1_data, o_rs1_busy,
                         exp_data(int'(i_rs1_addr)), exp_busy(int'(i_rs1_addr)));
            end
            checks++;
            if (o_rs2_data !== exp_data(int'(i_rs2_addr)) || o_rs2_busy !== exp_busy(int'(i_rs2_addr))) begin
                errors++;
                $display("FAIL rand_rs2 n=%0d a=%0d: got %h/%b, need %h/%b", n, i_rs2_addr, o_rs2_data, o_rs2_busy,
                         exp_data(int'(i_rs2_addr)), exp_busy(int'(i_rs2_addr)));
            end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        for (int a = 1; a < N_REG; a++) begin
            i_rd_we = 1'b1; i_rd_addr = AW'(a); i_rd_data = $urandom | 32'h1;
            i_rsv_en = 1'b1; i_rsv_addr = AW'(a);
            tick();
        end
        idle();
        i_rs1_addr = 5'd1; i_rs2_addr = 5'd31;
        #1;
        checks++;
        if (o_rs1_data !== mdata[1] || o_rs2_busy !== 1'b1) begin
            errors++;
            $display("FAIL preload: got %h busy %b, need %h/1", o_rs1_data, o_rs2_busy, mdata[1]);
        end
        // Pending write/reserve while reset drops mid-cycle must never land.
        i_rd_we = 1'b1; i_rd_addr = 5'd1; i_rd_data = 32'h55AA55AA;
        i_rsv_en = 1'b1; i_rsv_addr = 5'd31;
        #1;
        i_rstn = 1'b0;
        model_clear();
        #1;
        checks++;
        if (o_rs1_data !== '0 || o_rs2_data !== '0 || o_rs1_busy !== 1'b0 || o_rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got %h %h %b %b, need all zero", o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy);
        end
        @(posedge i_clk);
        #2;
        idle();
        i_rstn = 1'b1;
        for (int a = 0; a < N_REG; a++) begin
            i_rs1_addr = AW'(a);
            i_rs2_addr = AW'(a);
            #1;
            checks++;
            if (o_rs1_data !== '0 || o_rs2_data !== '0 || o_rs1_busy !== 1'b0 || o_rs2_busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset a=%0d: got %h %h %b %b, need all zero", a, o_rs1_data, o_rs2_data, o_rs1_busy, o_rs2_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reserve();
        test_same_cycle();
        test_bypass();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
